// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared defaults, FSM state encoding and byte-merge helper for gpr_file_hs
package gpr_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // One byte lane of a byte-enabled write.
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/gpr_be_merge.sv
// rtl/gpr_be_merge.sv - combinational byte-enable merge of new data into an existing word
module gpr_be_merge
  import gpr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      merged[8*i +: 8] = be_merge(old_data[8*i +: 8], new_data[8*i +: 8], be[i]);
    end
  end

endmodule

// File: rtl/gpr_file_hs.sv
// rtl/gpr_file_hs.sv - register file with handshaked load/store port A and registered operand port B
module gpr_file_hs
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdy,
  output logic                ack,
  output logic                err,
  input  logic                rb_en,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data
);

  localparam int              BE_W    = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nx;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [BE_W-1:0]     req_be;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                a_ok, b_ok, a_zero, b_zero, commit;
  logic [IDX_W-1:0]    a_idx, b_idx;
  logic [DATA_W-1:0]   a_old, merged;

  // Full-width range check first; only then are the low index bits meaningful.
  assign a_ok   = {1'b0, req_addr} < DEPTH_X;
  assign b_ok   = {1'b0, rb_addr} < DEPTH_X;
  assign a_zero = (ZERO_REG != 0) && (req_addr == '0);
  assign b_zero = (ZERO_REG != 0) && (rb_addr == '0);
  assign a_idx  = req_addr[IDX_W-1:0];
  assign b_idx  = rb_addr[IDX_W-1:0];
  assign a_old  = mem[a_idx];
  assign commit = (state == ST_ACCESS) && req_we && a_ok && !a_zero;

  gpr_be_merge #(.DATA_W(DATA_W)) u_merge (
    .old_data (a_old),
    .new_data (req_wdata),
    .be       (req_be),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    ack      = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (cs) state_nx = ST_ACCESS;
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP: begin
        ack      = 1'b1;
        err      = !a_ok;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
    end else if (state == ST_IDLE && cs) begin
      req_we    <= we;
      req_addr  <= addr;
      req_wdata <= wdata;
      req_be    <= be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[a_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (state == ST_ACCESS && !req_we) begin
      rdata <= (a_ok && !a_zero) ? a_old : '0;
    end
  end

  // Port B sees a same-edge port A write as already committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data <= '0;
    end else if (rb_en) begin
      if (b_ok && !b_zero) rb_data <= (commit && rb_addr == req_addr) ? merged : mem[b_idx];
      else                 rb_data <= '0;
    end
  end

endmodule
